mean_square_acc: RTL and testbench
==================================

// Module: mean_square_acc
// PURPOSE
//  Windowed mean-square accumulator. Sits directly upstream of the 48-bit square-root stage.
//  Squares each signed ADC voltage/current sample and sums N = 2^LOG2_N squares per window.
//  Emits sum >> LOG2_N as a 48-bit unsigned mean square, which feeds the sqrt num input (RMS).
//  Windows are aligned to a mains-cycle sync (zero-crossing) pulse.
// PARAMETERS
//  DATA_W    24  sample width, two's complement
//  LOG2_N    8   log2 of samples per window (256 @ 12.8 kS/s = one 50 Hz cycle); legal 1..16
//  SYNC_REQ  1   1: ignore samples after reset until the first sync; 0: accumulate immediately
// PORTS
//  clk           in   1         single clock, all logic on posedge
//  rst           in   1         synchronous, active-high reset
//  sample_in     in   DATA_W    signed sample
//  sample_valid  in   1         sample_in qualifier; one sample per cycle max
//  sync          in   1         window restart; when valid is high, the same-cycle sample is first of the new window
//  ms_out        out  2*DATA_W  unsigned mean square; held between updates
//  ms_valid      out  1         1-cycle pulse; ms_out is updated in the same cycle
//  partial_drop  out  1         1-cycle pulse: sync aborted a window holding >=1 sample
// BEHAVIOUR
//  Reset: ms_out=0, ms_valid=0, partial_drop=0, acc=0, cnt=0, pipeline valid/sync flags=0.
//   FSM goes to WAIT_SYNC if SYNC_REQ=1, else ACCUM.
//  Pipeline: 3 stages, fully pipelined, accepts a sample every cycle.
//   S1 registers sample, valid and sync. S2 registers sq = sample*sample, unsigned, 2*DATA_W-1 bits.
//   S3 accumulates. sync travels down the pipe with its sample, so alignment is exact.
//  Latency: last sample of a window valid at cycle t -> ms_valid at t+3.
//  Width: acc is 2*DATA_W-1+LOG2_N bits and never overflows. Max square is 2^(2*DATA_W-2), from -2^(DATA_W-1).
//   ms_out = acc_final[..LOG2_N] truncated (floor), zero-extended to 2*DATA_W bits.
//  FSM (evaluated at S3):
//   WAIT_SYNC: valid squares are discarded. On sync_s2 -> ACCUM.
//    If valid_s2 is also high, that square is the first of the window (acc=sq, cnt=1).
//   ACCUM, valid_s2 & !sync_s2: if cnt==N-1, then ms_out<=(acc+sq)>>LOG2_N, ms_valid<=1, acc<=0, cnt<=0.
//    Otherwise acc<=acc+sq, cnt<=cnt+1.
//   ACCUM, sync_s2: if cnt!=0, partial_drop<=1 and there is no ms_valid.
//    acc<=valid_s2?sq:0 and cnt<=valid_s2?1:0. State stays ACCUM.
//   !valid_s2 & !sync_s2: hold everything; gaps in valid never count as samples.
//  Boundaries:
//   Last sample of window N in the cycle before the first sample of window N+1: both are handled.
//    Emit and clear, then next window starts with no lost sample.
//   sync with the sample that would have been #N: that sample starts a new window.
//    The old window (N-1 samples) is dropped and partial_drop pulses.
//   sync while cnt==0 (e.g. right after emit): no partial_drop.
//   Reset mid-window or with samples in flight: everything is discarded, no ms_valid.
//    Outputs read reset values on the cycle after rst is sampled.
//   ms_valid and partial_drop never assert in the same cycle.
// STRUCTURE
//  Shared package/header mean_square_pkg holds:
//   DATA_W and LOG2_N defaults, the state encodings WAIT_SYNC=1'b0 and ACCUM=1'b1,
//   and the ACC_W derivation function 2*DATA_W-1+LOG2_N.
//  One sub-module, signed_square_reg: stages S1-S2 (register input, signed multiply, register product).
//   It maps onto a DSP block. The accumulator, counter and FSM stay in the top.
// TESTING
//  1 SYNC_REQ=1, reset, 300 valid samples of 1000 with no sync -> ms_valid never asserts, ms_out=0.
//  2 sync + 256 consecutive samples of 1000 -> ms_valid 3 cycles after last sample.
//    ms_out=1_000_000, single-cycle pulse.
//  3 sync + 256 samples of -8388608 -> ms_out=48'h4000_0000_0000, exact, no wrap.
//  4 Alternating +4096/-4096 with random 0-3 cycle valid gaps, 256 valid samples ->
//    ms_out=16_777_216. Back-to-back second window gives the same value with no lost sample.
//  5 sync, 100 samples of 500, sync with sample 2000, 255 more samples of 2000 ->
//    partial_drop pulse at the 2nd sync, then ms_out=4_000_000.
//  6 sync, 200 samples, then rst for 1 cycle with 3 samples in flight ->
//    ms_valid/partial_drop stay 0, ms_out=0. A fresh window after the next sync is correct.

Source files
------------

// File: rtl/mean_square_pkg.sv
// Shared defaults, FSM encoding and accumulator width derivation for the
// windowed mean-square accumulator.
package mean_square_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int LOG2_N_DEF = 8;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        ACCUM     = 1'b1
    } state_t;

    // Square is 2*DATA_W-1 bits; summing 2^LOG2_N of them needs LOG2_N more.
    function automatic int acc_w(input int data_w, input int log2_n);
        return 2 * data_w - 1 + log2_n;
    endfunction

endpackage

// File: rtl/signed_square_reg.sv
// Pipeline stages S1-S2: register the sample with its flags, then register
// its signed square. Shaped to map onto a single DSP block.
module signed_square_reg #(
    parameter int DATA_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     sample_in,
    input  logic                  sample_valid,
    input  logic                  sync,
    output logic [2*DATA_W-2:0]   sq,
    output logic                  valid_s2,
    output logic                  sync_s2
);

    localparam int SQ_W = 2 * DATA_W - 1;

    logic [DATA_W-1:0]          sample_r;
    logic                       valid_s1_r;
    logic                       sync_s1_r;
    logic signed [2*DATA_W-1:0] ext_s;
    logic [SQ_W-1:0]            sq_r;
    logic                       valid_s2_r;
    logic                       sync_s2_r;

    // The top product bit is always zero: the largest square is 2^(2*DATA_W-2).
    assign ext_s = {{DATA_W{sample_r[DATA_W-1]}}, sample_r};

    // S1 capture and S2 multiply; flags travel alongside their data.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_r   <= {DATA_W{1'b0}};
            valid_s1_r <= 1'b0;
            sync_s1_r  <= 1'b0;
            sq_r       <= {SQ_W{1'b0}};
            valid_s2_r <= 1'b0;
            sync_s2_r  <= 1'b0;
        end else begin
            sample_r   <= sample_in;
            valid_s1_r <= sample_valid;
            sync_s1_r  <= sync;
            sq_r       <= SQ_W'(ext_s * ext_s);
            valid_s2_r <= valid_s1_r;
            sync_s2_r  <= sync_s1_r;
        end
    end

    assign sq       = sq_r;
    assign valid_s2 = valid_s2_r;
    assign sync_s2  = sync_s2_r;

endmodule

// File: rtl/mean_square_acc.sv
// Windowed mean-square accumulator: squares signed samples, sums 2^LOG2_N per
// sync-aligned window and emits the floor mean for the downstream sqrt stage.
module mean_square_acc
    import mean_square_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOG2_N   = LOG2_N_DEF,
    parameter bit SYNC_REQ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     sample_in,
    input  logic                  sample_valid,
    input  logic                  sync,
    output logic [2*DATA_W-1:0]   ms_out,
    output logic                  ms_valid,
    output logic                  partial_drop
);

    localparam int SQ_W  = 2 * DATA_W - 1;
    localparam int OUT_W = 2 * DATA_W;
    localparam int ACC_W = acc_w(DATA_W, LOG2_N);
    localparam logic [LOG2_N-1:0] CNT_ZERO = {LOG2_N{1'b0}};
    localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1'b1);
    localparam logic [ACC_W-1:0]  ACC_ZERO = {ACC_W{1'b0}};

    logic [SQ_W-1:0]   sq_s;
    logic              valid_s2_s;
    logic              sync_s2_s;
    logic [ACC_W-1:0]  sq_ext_s;
    logic [ACC_W-1:0]  sum_s;
    logic [OUT_W-1:0]  mean_s;

    state_t            state_r;
    logic [ACC_W-1:0]  acc_r;
    logic [LOG2_N-1:0] cnt_r;
    logic [OUT_W-1:0]  ms_out_r;
    logic              ms_valid_r;
    logic              partial_drop_r;

    signed_square_reg #(
        .DATA_W (DATA_W)
    ) u_square (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sync         (sync),
        .sq           (sq_s),
        .valid_s2     (valid_s2_s),
        .sync_s2      (sync_s2_s)
    );

    assign sq_ext_s = {{LOG2_N{1'b0}}, sq_s};
    assign sum_s    = acc_r + sq_ext_s;
    assign mean_s   = {1'b0, sum_s[ACC_W-1:LOG2_N]};

    // S3: window FSM, accumulator and registered outputs. A sync always opens
    // a new window with its own sample, so emit and drop are mutually exclusive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= SYNC_REQ ? WAIT_SYNC : ACCUM;
            acc_r          <= ACC_ZERO;
            cnt_r          <= CNT_ZERO;
            ms_out_r       <= {OUT_W{1'b0}};
            ms_valid_r     <= 1'b0;
            partial_drop_r <= 1'b0;
        end else begin
            ms_valid_r     <= 1'b0;
            partial_drop_r <= 1'b0;
            case (state_r)
                WAIT_SYNC: begin
                    if (sync_s2_s) begin
                        state_r <= ACCUM;
                        acc_r   <= valid_s2_s ? sq_ext_s : ACC_ZERO;
                        cnt_r   <= valid_s2_s ? CNT_ONE : CNT_ZERO;
                    end else begin
                        state_r <= WAIT_SYNC;
                    end
                end
                ACCUM: begin
                    if (sync_s2_s) begin
                        partial_drop_r <= (cnt_r != CNT_ZERO);
                        acc_r          <= valid_s2_s ? sq_ext_s : ACC_ZERO;
                        cnt_r          <= valid_s2_s ? CNT_ONE : CNT_ZERO;
                    end else if (valid_s2_s) begin
                        if (&cnt_r) begin
                            ms_out_r   <= mean_s;
                            ms_valid_r <= 1'b1;
                            acc_r      <= ACC_ZERO;
                            cnt_r      <= CNT_ZERO;
                        end else begin
                            acc_r <= sum_s;
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                default: begin
                    state_r <= WAIT_SYNC;
                    acc_r   <= ACC_ZERO;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign ms_out       = ms_out_r;
    assign ms_valid     = ms_valid_r;
    assign partial_drop = partial_drop_r;

endmodule

// File: tb/tb_mean_square_acc.sv
// Scoreboard bench for mean_square_acc: the driver queues expected events with
// their due cycle, and a negedge monitor pops and compares them.
module tb_mean_square_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] sample_in;
    logic        sample_valid;
    logic        sync;
    logic [47:0] ms_out;
    logic        ms_valid;
    logic        partial_drop;

    typedef struct {
        bit          drop;
        logic [47:0] val;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_total  = 0;
    int   n_pass   = 0;

    mean_square_acc #(
        .DATA_W   (24),
        .LOG2_N   (8),
        .SYNC_REQ (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sync         (sync),
        .ms_out       (ms_out),
        .ms_valid     (ms_valid),
        .partial_drop (partial_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      name, act, act, expv, expv, cyc);
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (ms_valid === 1'b1 && partial_drop === 1'b1)
            chk("both_pulses", 64'd1, 64'd0);
        if (ms_valid === 1'b1 || partial_drop === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {62'd0, ms_valid, partial_drop}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("event_kind", {63'd0, partial_drop}, {63'd0, e.drop});
                chk("event_cycle", 64'(cyc), 64'(e.cyc));
                if (!e.drop) chk("ms_out", {16'd0, ms_out}, {16'd0, e.val});
            end
        end
    end

    task automatic step(input logic v, input logic s, input logic [23:0] d);
        sample_valid = v;
        sync         = s;
        sample_in    = d;
        @(posedge clk);
        #1;
    endtask

    // Sends n valid samples (sign alternates if alt), optional idle gaps before
    // all but the first; the last sample's result is expected 3 cycles later.
    task automatic send(input logic [23:0] d, input int n, input bit first_sync,
                        input bit alt, input int max_gap, input bit push,
                        input logic [47:0] expv);
        logic [23:0] v;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && max_gap > 0)
                repeat ($urandom_range(0, max_gap)) step(1'b0, 1'b0, 24'd0);
            v = (alt && (i % 2 == 1)) ? -d : d;
            if (push && i == n - 1) exp_q.push_back('{1'b0, expv, cyc + 3});
            step(1'b1, first_sync && (i == 0), v);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 24'd0);
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sync         = 1'b0;
        sample_in    = 24'd0;
        repeat (3) step(1'b0, 1'b0, 24'd0);
        rst = 1'b0;
        chk("reset_ms_out", {16'd0, ms_out}, 64'd0);
        chk("reset_ms_valid", {63'd0, ms_valid}, 64'd0);
        chk("reset_partial_drop", {63'd0, partial_drop}, 64'd0);

        // Before the first sync everything is ignored.
        send(24'sd1000, 300, 1'b0, 1'b0, 0, 1'b0, 48'd0);
        idle(5);
        chk("no_sync_ms_out", {16'd0, ms_out}, 64'd0);

        send(24'sd1000, 256, 1'b1, 1'b0, 0, 1'b1, 48'd1_000_000);
        idle(5);
        chk("held_ms_out", {16'd0, ms_out}, 64'd1_000_000);

        send(24'sh800000, 256, 1'b1, 1'b0, 0, 1'b1, 48'h4000_0000_0000);
        idle(5);

        // Gapped alternating window, then a back-to-back window without sync.
        send(24'sd4096, 256, 1'b1, 1'b1, 3, 1'b1, 48'd16_777_216);
        send(24'sd4096, 256, 1'b0, 1'b1, 0, 1'b1, 48'd16_777_216);
        idle(5);

        // Sync mid-window: drop the 100-sample window, sync sample opens the next.
        send(24'sd500, 100, 1'b1, 1'b0, 0, 1'b0, 48'd0);
        exp_q.push_back('{1'b1, 48'd0, cyc + 3});
        step(1'b1, 1'b1, 24'sd2000);
        send(24'sd2000, 255, 1'b0, 1'b0, 0, 1'b1, 48'd4_000_000);
        idle(5);

        // Reset while the window's last three samples are in flight.
        send(24'sd1000, 255, 1'b1, 1'b0, 0, 1'b0, 48'd0);
        rst = 1'b1;
        step(1'b1, 1'b0, 24'sd1000);
        rst = 1'b0;
        chk("rst_ms_out", {16'd0, ms_out}, 64'd0);
        chk("rst_ms_valid", {63'd0, ms_valid}, 64'd0);
        chk("rst_partial_drop", {63'd0, partial_drop}, 64'd0);
        idle(5);
        chk("post_rst_ms_out", {16'd0, ms_out}, 64'd0);

        send(24'sd7, 10, 1'b0, 1'b0, 0, 1'b0, 48'd0);
        send(24'sd3000, 256, 1'b1, 1'b0, 0, 1'b1, 48'd9_000_000);
        idle(6);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
